// File: rtl/pipeline_deliver_chain_if.sv
// Datapath bundle of the stall-aware delay chain: stall/flush control, input
// payload, and per-register observation outputs.
interface pipeline_deliver_chain_if #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3
);
    logic [STAGES:0]          stall;
    logic [STAGES-1:0]        flush;
    logic [WIDTH-1:0]         in;
    logic                     in_valid;
    logic [STAGES*WIDTH-1:0]  stage_data;
    logic [STAGES-1:0]        stage_valid;
    logic [WIDTH-1:0]         out;
    logic                     out_valid;
    logic                     busy;

    modport master (
        output stall, flush, in, in_valid,
        input  stage_data, stage_valid, out, out_valid, busy
    );

    modport slave (
        input  stall, flush, in, in_valid,
        output stage_data, stage_valid, out, out_valid, busy
    );
endinterface

// File: rtl/pipeline_deliver_chain.sv
// Chain of STAGES stall-aware pipeline registers with per-register flush,
// bubble insertion, and a saturating counter of empty slots taken by the consumer.
module pipeline_deliver_chain #(
    parameter int                 WIDTH        = 32,
    parameter int                 STAGES       = 3,
    parameter logic [WIDTH-1:0]   BUBBLE_VALUE = '0,
    parameter int                 CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_deliver_chain_if.slave bus,
    input  logic                  cnt_clear,
    output logic [CNT_WIDTH-1:0]  bubble_count
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0]  data_q    [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [WIDTH-1:0]  src_data  [STAGES];
    logic [STAGES-1:0] src_valid;

    // Register 0 is fed from the input port, every later register from its predecessor.
    always_comb begin
        src_data[0]  = bus.in;
        src_valid[0] = bus.in_valid;
        for (int i = 1; i < STAGES; i++) begin
            src_data[i]  = data_q[i-1];
            src_valid[i] = valid_q[i-1];
        end
    end

    // NOTE: payload registers are reset as well, since BUBBLE_VALUE is visible on stage_data.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STAGES; i++) begin
            if (rst || bus.flush[i] || (bus.stall[i] && !bus.stall[i+1])) begin
                // NOTE: non-blocking updates make every register see the pre-edge
                // value of its predecessor, giving a true shift with no fall-through.
                data_q[i]  <= BUBBLE_VALUE;
                valid_q[i] <= 1'b0;
            end else if (!bus.stall[i]) begin
                data_q[i]  <= src_data[i];
                valid_q[i] <= src_valid[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clear) begin
            bubble_count <= '0;
        end else if (!bus.stall[STAGES] && !valid_q[STAGES-1] && bubble_count != CNT_MAX) begin
            bubble_count <= bubble_count + 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            bus.stage_data[i*WIDTH +: WIDTH] = data_q[i];
        end
    end

    assign bus.stage_valid = valid_q;
    assign bus.out         = data_q[STAGES-1];
    assign bus.out_valid   = valid_q[STAGES-1];
    assign bus.busy        = |valid_q;
endmodule

// File: tb/tb_pipeline_deliver_chain.sv
// Scoreboard bench for pipeline_deliver_chain: two builds (bubble 0x00 and 0xFF)
// share stimulus; a slot-level reference model predicts every post-edge state.
module tb_pipeline_deliver_chain;
    localparam int WIDTH     = 8;
    localparam int STAGES    = 3;
    localparam int CNT_WIDTH = 4;

    typedef struct packed {
        logic [STAGES*WIDTH-1:0] data0;
        logic [STAGES*WIDTH-1:0] data1;
        logic [STAGES-1:0]       valid;
        logic [CNT_WIDTH-1:0]    cnt;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst       = 1'b1;
    logic                 cnt_clear = 1'b0;
    logic [STAGES:0]      stall     = '0;
    logic [STAGES-1:0]    flush     = '0;
    logic [WIDTH-1:0]     din       = '0;
    logic                 din_valid = 1'b0;
    logic [CNT_WIDTH-1:0] cnt0, cnt1;

    pipeline_deliver_chain_if #(.WIDTH(WIDTH), .STAGES(STAGES)) bus0 ();
    pipeline_deliver_chain_if #(.WIDTH(WIDTH), .STAGES(STAGES)) bus1 ();

    assign bus0.stall = stall;  assign bus1.stall = stall;
    assign bus0.flush = flush;  assign bus1.flush = flush;
    assign bus0.in = din;       assign bus1.in = din;
    assign bus0.in_valid = din_valid;
    assign bus1.in_valid = din_valid;

    pipeline_deliver_chain #(.WIDTH(WIDTH), .STAGES(STAGES), .BUBBLE_VALUE(8'h00), .CNT_WIDTH(CNT_WIDTH)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .cnt_clear(cnt_clear), .bubble_count(cnt0));
    pipeline_deliver_chain #(.WIDTH(WIDTH), .STAGES(STAGES), .BUBBLE_VALUE(8'hFF), .CNT_WIDTH(CNT_WIDTH)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .cnt_clear(cnt_clear), .bubble_count(cnt1));

    int n_pass  = 0;
    int n_total = 0;
    exp_t sb[$];

    // Reference model: one slot per register, plus the counter of accepted empty slots.
    logic [WIDTH-1:0]     m_data [2][STAGES];
    logic [STAGES-1:0]    m_valid = '0;
    logic [CNT_WIDTH-1:0] m_cnt   = '0;
    logic [WIDTH-1:0]     bubble [2] = '{8'h00, 8'hFF};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic model_step();
        logic [WIDTH-1:0]  nd [2][STAGES];
        logic [STAGES-1:0] nv;
        logic [WIDTH-1:0]  up_d;
        logic              up_v;
        exp_t e;
        for (int i = 0; i < STAGES; i++) begin
            for (int b = 0; b < 2; b++) begin
                if (i == 0) begin up_d = din; up_v = din_valid; end
                else begin up_d = m_data[b][i-1]; up_v = m_valid[i-1]; end
                if (rst || flush[i]) begin
                    nd[b][i] = bubble[b]; nv[i] = 1'b0;
                end else if (stall[i] && !stall[i+1]) begin
                    nd[b][i] = bubble[b]; nv[i] = 1'b0;   // consumer moves on, producer cannot
                end else if (stall[i]) begin
                    nd[b][i] = m_data[b][i]; nv[i] = m_valid[i];
                end else begin
                    nd[b][i] = up_d; nv[i] = up_v;
                end
            end
        end
        if (rst || cnt_clear) m_cnt = '0;
        else if (!stall[STAGES] && !m_valid[STAGES-1] && m_cnt < 4'd15) m_cnt = m_cnt + 4'd1;
        m_data  = nd;
        m_valid = nv;
        for (int i = 0; i < STAGES; i++) begin
            e.data0[i*WIDTH +: WIDTH] = m_data[0][i];
            e.data1[i*WIDTH +: WIDTH] = m_data[1][i];
        end
        e.valid = m_valid;
        e.cnt   = m_cnt;
        sb.push_back(e);
    endtask

    task automatic step(input logic r, input logic cc, input logic [STAGES:0] s,
                        input logic [STAGES-1:0] f, input logic [WIDTH-1:0] d, input logic dv);
        @(negedge clk);
        rst = r; cnt_clear = cc; stall = s; flush = f; din = d; din_valid = dv;
        model_step();
    endtask

    task automatic observe();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every edge that completes a scheduled step is compared against the model.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("stage_data0", 32'(bus0.stage_data), 32'(e.data0));
                check("stage_data1", 32'(bus1.stage_data), 32'(e.data1));
                check("stage_valid0", 32'(bus0.stage_valid), 32'(e.valid));
                check("stage_valid1", 32'(bus1.stage_valid), 32'(e.valid));
                check("out0", 32'(bus0.out), 32'(e.data0[STAGES*WIDTH-1 -: WIDTH]));
                check("out_valid0", 32'(bus0.out_valid), 32'(e.valid[STAGES-1]));
                check("busy0", 32'(bus0.busy), 32'(e.valid != '0));
                check("busy1", 32'(bus1.busy), 32'(e.valid != '0));
                check("bubble_count0", 32'(cnt0), 32'(e.cnt));
                check("bubble_count1", 32'(cnt1), 32'(e.cnt));
            end
        end
    end

    initial begin
        logic [STAGES:0]   rs;
        logic [STAGES-1:0] rf;
        int                guard;

        // Reset
        step(1, 0, 4'b0000, 3'b000, 8'h00, 0);
        observe();
        check("reset_busy", 32'(bus0.busy), 32'd0);
        check("reset_data_ff", 32'(bus1.stage_data), 32'hFFFFFF);

        // Flow: three back-to-back loads emerge after three edges
        step(0, 0, 4'b0000, 3'b000, 8'h11, 1);
        step(0, 0, 4'b0000, 3'b000, 8'h22, 1);
        step(0, 0, 4'b0000, 3'b000, 8'h33, 1);
        observe();
        check("flow_out_11", 32'({bus0.out_valid, bus0.out}), 32'h111);
        step(0, 0, 4'b0000, 3'b000, 8'h00, 0);
        observe();
        check("flow_out_22", 32'(bus0.out), 32'h22);
        step(0, 0, 4'b0000, 3'b000, 8'h00, 0);
        observe();
        check("flow_out_33", 32'(bus0.out), 32'h33);

        // Bubble insertion between registers 0 and 1
        step(0, 0, 4'b0000, 3'b000, 8'hA3, 1);
        step(0, 0, 4'b0000, 3'b000, 8'hA2, 1);
        step(0, 0, 4'b0000, 3'b000, 8'hA1, 1);
        step(0, 0, 4'b0011, 3'b000, 8'hBB, 1);
        observe();
        check("bubble_data0", 32'(bus0.stage_data), 32'hA200A1);
        check("bubble_data1", 32'(bus1.stage_data), 32'hA2FFA1);
        check("bubble_valid", 32'(bus0.stage_valid), 32'b101);

        // Full hold
        for (int k = 0; k < 5; k++) step(0, 0, 4'b1111, 3'b000, 8'($urandom), 1'($urandom));
        observe();
        check("hold_data", 32'(bus0.stage_data), 32'hA200A1);

        // Flush of register 1 while register 0 holds 0x55
        step(0, 0, 4'b0000, 3'b000, 8'h44, 1);
        step(0, 0, 4'b0000, 3'b000, 8'h55, 1);
        step(0, 0, 4'b0000, 3'b010, 8'h55, 1);
        observe();
        check("flush_data", 32'(bus0.stage_data), 32'h440055);
        check("flush_valid", 32'(bus0.stage_valid), 32'b101);
        step(0, 0, 4'b0000, 3'b000, 8'h77, 1);
        observe();
        check("after_flush_data", 32'(bus0.stage_data), 32'h005577);

        // Counter saturation and clear priority
        step(1, 0, 4'b0000, 3'b000, 8'h00, 0);
        for (int k = 0; k < 20; k++) step(0, 0, 4'b0000, 3'b000, 8'h00, 0);
        observe();
        check("cnt_saturate", 32'(cnt0), 32'd15);
        step(0, 1, 4'b0000, 3'b000, 8'h00, 0);
        observe();
        check("cnt_clear", 32'(cnt0), 32'd0);

        // Reset while stalled with valid data
        for (int k = 0; k < 3; k++) step(0, 0, 4'b0000, 3'b000, 8'(8'h90 + k), 1);
        step(0, 0, 4'b1111, 3'b000, 8'h00, 0);
        step(1, 0, 4'b1111, 3'b101, 8'hEE, 1);
        observe();
        check("rst_stall_data0", 32'(bus0.stage_data), 32'd0);
        check("rst_stall_data1", 32'(bus1.stage_data), 32'hFFFFFF);
        check("rst_stall_valid", 32'(bus0.stage_valid), 32'd0);

        // Randomised traffic
        for (int k = 0; k < 800; k++) begin
            for (int b = 0; b <= STAGES; b++) rs[b] = ($urandom_range(0, 9) < 3);
            for (int b = 0; b < STAGES; b++)  rf[b] = ($urandom_range(0, 9) == 0);
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0), rs, rf,
                 8'($urandom), ($urandom_range(0, 3) != 0));
        end

        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #3;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
